// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the dmem arbiter: port indices and the stats counter width.
package dmem_arb_pkg;

    typedef logic port_idx_t;

    localparam port_idx_t PORT_CPU = 1'b0;
    localparam port_idx_t PORT_DBG = 1'b1;

    localparam int unsigned CONFLICT_W = 16;

    // Saturating increment for the contention counter.
    function automatic logic [CONFLICT_W-1:0] sat_inc(input logic [CONFLICT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with a registered "last granted" pointer.
// Grants are forced low while reset is asserted.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    port_idx_t last;

    // Grant decode: a lone requester wins, contention goes to the port that was not last served.
    always_comb begin
        gnt = 2'b00;
        if (!reset) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (last == PORT_CPU) ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    // Pointer update: starts at the debug port so the processor wins the first contention.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last <= PORT_DBG;
        end else if (gnt[0]) begin
            last <= PORT_CPU;
        end else if (gnt[1]) begin
            last <= PORT_DBG;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port dmem syncram between the processor (port 0) and the
// debug/loader master (port 1). One access per cycle, round-robin on contention,
// read data steered back to the issuing port one cycle after its grant.
// Optional contention statistics are compiled in with DMEM_ARB_STATS_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              wren0,
    input  logic              wren1,
    input  logic [ADDR_W-1:0] address0,
    input  logic [ADDR_W-1:0] address1,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] q0,
    output logic [DATA_W-1:0] q1,
    output logic [ADDR_W-1:0] address_dmem,
    output logic [DATA_W-1:0] data,
    output logic              wren,
    input  logic [DATA_W-1:0] q_dmem
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [CONFLICT_W-1:0] conflict_count
`endif
);

    logic [1:0]        gnt;
    logic              any_gnt;
    port_idx_t         sel_port;
    logic              sel_wren;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_data;
    logic              rd_pend;
    port_idx_t         rd_owner;

    rr_arb2 u_rr_arb2 (
        .clock (clock),
        .reset (reset),
        .req   ({req1, req0}),
        .gnt   (gnt)
    );

    assign gnt0    = gnt[0];
    assign gnt1    = gnt[1];
    assign any_gnt = |gnt;

    // Select the granted port's command fields.
    always_comb begin
        sel_port = gnt[1] ? PORT_DBG : PORT_CPU;
        sel_wren = (sel_port == PORT_DBG) ? wren1    : wren0;
        sel_addr = (sel_port == PORT_DBG) ? address1 : address0;
        sel_data = (sel_port == PORT_DBG) ? data1    : data0;
    end

    // Memory drive: granted command, otherwise park on the last address/data with wren low.
    always_comb begin
        address_dmem = hold_addr;
        data         = hold_data;
        wren         = 1'b0;
        if (any_gnt) begin
            address_dmem = sel_addr;
            data         = sel_data;
            wren         = sel_wren;
        end
    end

    // Remember the last driven address/data so the idle bus does not toggle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_addr <= '0;
            hold_data <= '0;
        end else if (any_gnt) begin
            hold_addr <= sel_addr;
            hold_data <= sel_data;
        end
    end

    // Track the read in flight; reset discards it for good.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_pend  <= 1'b0;
            rd_owner <= PORT_CPU;
        end else begin
            rd_pend <= any_gnt && !sel_wren;
            if (any_gnt) begin
                rd_owner <= sel_port;
            end
        end
    end

    // Steer the syncram output to the owner; the other port sees zero.
    always_comb begin
        rvalid0 = rd_pend && (rd_owner == PORT_CPU);
        rvalid1 = rd_pend && (rd_owner == PORT_DBG);
        q0      = rvalid0 ? q_dmem : '0;
        q1      = rvalid1 ? q_dmem : '0;
    end

`ifdef DMEM_ARB_STATS_EN
    // Count cycles with both ports requesting, saturating at all-ones.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            conflict_count <= '0;
        end else if (req0 && req1) begin
            conflict_count <= sat_inc(conflict_count);
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized self-checking bench for dmem_arbiter with a behavioural reference model
// and a behavioural single-port syncram. Stats checks are built with DMEM_ARB_STATS_EN.
module tb_dmem_arbiter;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 32;

    logic              clock = 1'b0;
    logic              reset;
    logic              req0, req1, wren0, wren1;
    logic [ADDR_W-1:0] address0, address1;
    logic [DATA_W-1:0] data0, data1;
    logic              gnt0, gnt1, rvalid0, rvalid1;
    logic [DATA_W-1:0] q0, q1;
    logic [ADDR_W-1:0] address_dmem;
    logic [DATA_W-1:0] data;
    logic              wren;
    logic [DATA_W-1:0] q_dmem;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0]       conflict_count;
`endif

    always #5 clock = ~clock;

    dmem_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req0         (req0),
        .req1         (req1),
        .wren0        (wren0),
        .wren1        (wren1),
        .address0     (address0),
        .address1     (address1),
        .data0        (data0),
        .data1        (data1),
        .gnt0         (gnt0),
        .gnt1         (gnt1),
        .rvalid0      (rvalid0),
        .rvalid1      (rvalid1),
        .q0           (q0),
        .q1           (q1),
        .address_dmem (address_dmem),
        .data         (data),
        .wren         (wren),
        .q_dmem       (q_dmem)
`ifdef DMEM_ARB_STATS_EN
        ,
        .conflict_count (conflict_count)
`endif
    );

    // Preloaded memory contents (0x010 holds DEADBEEF).
    function automatic logic [31:0] init_word(input logic [11:0] a);
        if (a == 12'h010) return 32'hDEADBEEF;
        return 32'h1000_0000 ^ (32'(a) * 32'h9E37_79B1);
    endfunction

    // Behavioural syncram: registered read, writes visible from the next access.
    bit [31:0] mem    [4096];
    bit        mem_wr [4096];
    always @(posedge clock) begin
        if (wren) begin
            mem[address_dmem]    <= data;
            mem_wr[address_dmem] <= 1'b1;
        end
        q_dmem <= mem_wr[address_dmem] ? mem[address_dmem] : init_word(address_dmem);
    end

    // Reference model state.
    typedef struct {
        bit          act;
        bit          wr;
        logic [11:0] addr;
        logic [31:0] dat;
    } cmd_t;

    cmd_t        cmd [2];
    logic [31:0] ref_mem [4096];
    bit          ref_wr  [4096];
    int          m_last;
    bit          m_pend;
    int          m_owner;
    logic [31:0] m_rdata;
    logic [11:0] m_haddr;
    logic [31:0] m_hdata;
    int          m_cnt;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_read(input logic [11:0] a);
        return ref_wr[a] ? ref_mem[a] : init_word(a);
    endfunction

    task automatic model_reset();
        m_last  = 1;
        m_pend  = 1'b0;
        m_owner = 0;
        m_rdata = '0;
        m_haddr = '0;
        m_hdata = '0;
        m_cnt   = 0;
        cmd[0].act = 1'b0;
        cmd[1].act = 1'b0;
    endtask

    task automatic apply();
        req0     = cmd[0].act;
        wren0    = cmd[0].wr;
        address0 = cmd[0].addr;
        data0    = cmd[0].dat;
        req1     = cmd[1].act;
        wren1    = cmd[1].wr;
        address1 = cmd[1].addr;
        data1    = cmd[1].dat;
    endtask

    // One clock cycle: compare at the falling edge, then advance the model across the rising edge.
    task automatic cycle();
        int          g;
        int          gi;
        logic        e_wren;
        logic [11:0] e_addr;
        logic [31:0] e_data;
        @(negedge clock);
        if (cmd[0].act && cmd[1].act) g = (m_last == 0) ? 1 : 0;
        else if (cmd[0].act)          g = 0;
        else if (cmd[1].act)          g = 1;
        else                          g = -1;
        gi     = (g < 0) ? 0 : g;
        e_wren = (g >= 0) ? cmd[gi].wr   : 1'b0;
        e_addr = (g >= 0) ? cmd[gi].addr : m_haddr;
        e_data = (g >= 0) ? cmd[gi].dat  : m_hdata;
        check_eq("gnt0", 32'(gnt0), 32'(g == 0));
        check_eq("gnt1", 32'(gnt1), 32'(g == 1));
        check_eq("wren", 32'(wren), 32'(e_wren));
        check_eq("address_dmem", 32'(address_dmem), 32'(e_addr));
        check_eq("data", data, e_data);
        check_eq("rvalid0", 32'(rvalid0), 32'(m_pend && m_owner == 0));
        check_eq("rvalid1", 32'(rvalid1), 32'(m_pend && m_owner == 1));
        check_eq("q0", q0, (m_pend && m_owner == 0) ? m_rdata : 32'h0);
        check_eq("q1", q1, (m_pend && m_owner == 1) ? m_rdata : 32'h0);
`ifdef DMEM_ARB_STATS_EN
        check_eq("conflict_count", 32'(conflict_count), 32'(m_cnt));
        if (cmd[0].act && cmd[1].act && m_cnt < 65535) m_cnt++;
`endif
        m_pend = 1'b0;
        if (g >= 0) begin
            m_last  = g;
            m_haddr = cmd[gi].addr;
            m_hdata = cmd[gi].dat;
            if (cmd[gi].wr) begin
                ref_mem[cmd[gi].addr] = cmd[gi].dat;
                ref_wr[cmd[gi].addr]  = 1'b1;
            end else begin
                m_pend  = 1'b1;
                m_owner = g;
                m_rdata = ref_read(cmd[gi].addr);
            end
        end
        @(posedge clock);
        #1;
        if (g >= 0) cmd[gi].act = 1'b0;
    endtask

    task automatic set_cmd(input int p, input bit wr, input logic [11:0] a, input logic [31:0] d);
        cmd[p].act  = 1'b1;
        cmd[p].wr   = wr;
        cmd[p].addr = a;
        cmd[p].dat  = d;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_gnt0"}, 32'(gnt0), 32'h0);
        check_eq({tag, "_gnt1"}, 32'(gnt1), 32'h0);
        check_eq({tag, "_wren"}, 32'(wren), 32'h0);
        check_eq({tag, "_addr"}, 32'(address_dmem), 32'h0);
        check_eq({tag, "_data"}, data, 32'h0);
        check_eq({tag, "_rvalid0"}, 32'(rvalid0), 32'h0);
        check_eq({tag, "_rvalid1"}, 32'(rvalid1), 32'h0);
        check_eq({tag, "_q0"}, q0, 32'h0);
        check_eq({tag, "_q1"}, q1, 32'h0);
    endtask

    initial begin
        reset = 1'b1;
        cmd[0] = '{act: 1'b0, wr: 1'b0, addr: 12'h0, dat: 32'h0};
        cmd[1] = '{act: 1'b0, wr: 1'b0, addr: 12'h0, dat: 32'h0};
        apply();
        // Requests held during reset must not be granted.
        req0 = 1'b1;
        req1 = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check_all_zero("in_reset");
        reset = 1'b0;
        model_reset();

        // First contention after reset goes to port 0.
        set_cmd(0, 1'b0, 12'h001, 32'h0);
        set_cmd(1, 1'b0, 12'h002, 32'h0);
        apply();
        cycle();
        apply();
        cycle();
        apply();
        cycle();

        // Single read of the preloaded word.
        set_cmd(0, 1'b0, 12'h010, 32'h0);
        apply();
        cycle();
        apply();
        cycle();

        // Sustained contention: both ports re-request as soon as served.
        for (int i = 0; i < 6; i++) begin
            if (!cmd[0].act) set_cmd(0, 1'b0, 12'h001, 32'h0);
            if (!cmd[1].act) set_cmd(1, 1'b0, 12'h002, 32'h0);
            apply();
            cycle();
        end
        cmd[0].act = 1'b0;
        cmd[1].act = 1'b0;
        apply();
        cycle();
        cycle();

        // Write on port 1, then read back on port 0.
        set_cmd(1, 1'b1, 12'h0FF, 32'h12345678);
        apply();
        cycle();
        set_cmd(0, 1'b0, 12'h0FF, 32'h0);
        apply();
        cycle();
        apply();
        cycle();

        // Reset asserted mid-cycle while a read result is on its way out.
        set_cmd(0, 1'b0, 12'h010, 32'h0);
        apply();
        cycle();
        req0     = 1'b1;
        wren0    = 1'b0;
        address0 = 12'h020;
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        apply();
        cycle();
        cycle();
        set_cmd(0, 1'b0, 12'h003, 32'h0);
        set_cmd(1, 1'b0, 12'h004, 32'h0);
        apply();
        cycle();
        apply();
        cycle();
        apply();
        cycle();

        // Random traffic over a small address window to mix reads and writes.
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (!cmd[p].act && $urandom_range(0, 99) < 65) begin
                    set_cmd(p, ($urandom_range(0, 2) == 0), 12'($urandom_range(0, 15)), $urandom);
                end
            end
            apply();
            cycle();
        end

`ifdef DMEM_ARB_STATS_EN
        reset = 1'b1;
        #2;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 10; i++) begin
            if (!cmd[0].act) set_cmd(0, 1'b0, 12'h005, 32'h0);
            if (!cmd[1].act) set_cmd(1, 1'b0, 12'h006, 32'h0);
            apply();
            cycle();
        end
        cmd[0].act = 1'b0;
        cmd[1].act = 1'b0;
        apply();
        @(negedge clock);
        check_eq("conflict_10", 32'(conflict_count), 32'd10);
        req0 = 1'b1;
        req1 = 1'b1;
        repeat (70000) @(posedge clock);
        @(negedge clock);
        check_eq("conflict_sat", 32'(conflict_count), 32'h0000FFFF);
        req0 = 1'b0;
        req1 = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
